fir_tap_scheduler: RTL and testbench

FIR_TAP_SCHEDULER -- requirements
Module: fir_tap_scheduler

---
 rtl/fir_tap_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_fir_tap_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_tap_scheduler                                             |
// | Purpose  : Sequences a 40-tap FIR built from four 10-word coefficient    |
// |            RAM banks. Per sample strobe: one delay-shift/acc-clear      |
// |            cycle, ten MAC read cycles (all banks in parallel), one      |
// |            flush cycle for the RAM read latency, one final-sum cycle.   |
// |            In update mode host writes are routed to the owning bank.    |
// | Ports    : iClk_12M, iRst (async, active-high)                           |
// |            iEnSample_600k     sample strobe                              |
// |            iCoeffiUpdateFlag  coefficient update mode request            |
// |            iCsnRam/iWrnRam/iAddrRam/iWrDtRam  host RAM port              |
// |            iNumOfCoeff        active tap count (clamped to 40)           |
// |            oCsnRam/oWrnRam/oAddrRam/oWrDtRam  bank RAM port              |
// |            oEnDelay/oClrAcc/oEnSum/oEnMac     datapath controls          |
// |            oBusy, oOvrRun                                                |
// | Config   : FIR_SCHED_OVRRUN_EN - sticky overrun flag on dropped strobes |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fir_tap_scheduler (
    input  logic        iClk_12M,
    input  logic        iRst,
    input  logic        iEnSample_600k,
    input  logic        iCoeffiUpdateFlag,
    input  logic        iCsnRam,
    input  logic        iWrnRam,
    input  logic [5:0]  iAddrRam,
    input  logic [15:0] iWrDtRam,
    input  logic [5:0]  iNumOfCoeff,
    output logic [3:0]  oCsnRam,
    output logic [3:0]  oWrnRam,
    output logic [3:0]  oAddrRam,
    output logic [15:0] oWrDtRam,
    output logic        oEnDelay,
    output logic        oClrAcc,
    output logic        oEnSum,
    output logic [3:0]  oEnMac,
    output logic        oBusy,
    output logic        oOvrRun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UPDATE = 3'd1,
        S_CLEAR  = 3'd2,
        S_MAC    = 3'd3,
        S_FLUSH  = 3'd4,
        S_SUM    = 3'd5
    } state_t;

    localparam logic [5:0] C_MAX_TAPS = 6'd40;
    localparam logic [3:0] C_LAST_TAP = 4'd9;

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [5:0]  neff_q, neff_d;
    logic [3:0]  csn_q, csn_d;
    logic [3:0]  wrn_q, wrn_d;
    logic [3:0]  addr_q, addr_d;
    logic [15:0] wrdt_q, wrdt_d;
    logic        en_delay_q, en_delay_d;
    logic        clr_acc_q, clr_acc_d;
    logic        en_sum_q, en_sum_d;
    logic [3:0]  en_mac_q, en_mac_d;
    logic        busy_q, busy_d;

    // Host write decode: global index -> bank and local address.
    logic       w_wr_valid;
    logic [1:0] w_wr_bank;
    logic [3:0] w_wr_local;

    assign w_wr_valid = !iCsnRam && !iWrnRam && (iAddrRam < C_MAX_TAPS);

    always_comb begin
        w_wr_bank  = 2'd0;
        w_wr_local = iAddrRam[3:0];
        if (iAddrRam >= 6'd30) begin
            w_wr_bank  = 2'd3;
            w_wr_local = 4'(iAddrRam - 6'd30);
        end else if (iAddrRam >= 6'd20) begin
            w_wr_bank  = 2'd2;
            w_wr_local = 4'(iAddrRam - 6'd20);
        end else if (iAddrRam >= 6'd10) begin
            w_wr_bank  = 2'd1;
            w_wr_local = 4'(iAddrRam - 6'd10);
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        neff_d     = neff_q;
        csn_d      = 4'b1111;
        wrn_d      = 4'b1111;
        addr_d     = 4'd0;
        wrdt_d     = wrdt_q;
        en_delay_d = 1'b0;
        clr_acc_d  = 1'b0;
        en_sum_d   = 1'b0;
        busy_d     = 1'b0;
        // A bank read issued last MAC cycle returns data now; FLUSH catches k=9.
        en_mac_d   = (state_q == S_MAC) ? ~csn_q : 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (iCoeffiUpdateFlag) begin
                    state_d = S_UPDATE;
                end else if (iEnSample_600k) begin
                    state_d = S_CLEAR;
                end
            end
            S_UPDATE: begin
                // A write seen on the last update cycle still completes.
                if (w_wr_valid) begin
                    csn_d[w_wr_bank] = 1'b0;
                    wrn_d[w_wr_bank] = 1'b0;
                    addr_d           = w_wr_local;
                    wrdt_d           = iWrDtRam;
                end
                if (!iCoeffiUpdateFlag) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                neff_d  = (iNumOfCoeff > C_MAX_TAPS) ? C_MAX_TAPS : iNumOfCoeff;
                k_d     = 4'd0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == C_LAST_TAP) begin
                    state_d = S_FLUSH;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_FLUSH: state_d = S_SUM;
            S_SUM:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        case (state_d)
            S_CLEAR: begin
                en_delay_d = 1'b1;
                clr_acc_d  = 1'b1;
                busy_d     = 1'b1;
            end
            S_MAC: begin
                busy_d = 1'b1;
                addr_d = k_d;
                for (int b = 0; b < 4; b++) begin
                    if ((6'(10 * b) + {2'b00, k_d}) < neff_d) begin
                        csn_d[b] = 1'b0;
                    end
                end
            end
            S_FLUSH: busy_d = 1'b1;
            S_SUM: begin
                busy_d   = 1'b1;
                en_sum_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            k_q        <= 4'd0;
            neff_q     <= 6'd0;
            csn_q      <= 4'b1111;
            wrn_q      <= 4'b1111;
            addr_q     <= 4'd0;
            wrdt_q     <= 16'd0;
            en_delay_q <= 1'b0;
            clr_acc_q  <= 1'b0;
            en_sum_q   <= 1'b0;
            en_mac_q   <= 4'b0000;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            neff_q     <= neff_d;
            csn_q      <= csn_d;
            wrn_q      <= wrn_d;
            addr_q     <= addr_d;
            wrdt_q     <= wrdt_d;
            en_delay_q <= en_delay_d;
            clr_acc_q  <= clr_acc_d;
            en_sum_q   <= en_sum_d;
            en_mac_q   <= en_mac_d;
            busy_q     <= busy_d;
        end
    end

`ifdef FIR_SCHED_OVRRUN_EN
    // Strobe arriving while a run is in flight is dropped and flagged.
    logic w_drop;
    logic ovr_q;

    assign w_drop = iEnSample_600k && busy_q;

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            ovr_q <= 1'b0;
        end else if (w_drop) begin
            ovr_q <= 1'b1;
        end
    end

    assign oOvrRun = ovr_q;
`else
    assign oOvrRun = 1'b0;
`endif

    assign oCsnRam  = csn_q;
    assign oWrnRam  = wrn_q;
    assign oAddrRam = addr_q;
    assign oWrDtRam = wrdt_q;
    assign oEnDelay = en_delay_q;
    assign oClrAcc  = clr_acc_q;
    assign oEnSum   = en_sum_q;
    assign oEnMac   = en_mac_q;
    assign oBusy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_tap_scheduler                                          |
// | Purpose  : Self-checking bench for fir_tap_scheduler; expected traces    |
// |            are derived from tap arithmetic (tap 10*b+k active when below |
// |            min(N,40)) and fixed strobe-relative offsets.                 |
// | Config   : FIR_SCHED_OVRRUN_EN selects the expected overrun behaviour.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fir_tap_scheduler;

`ifdef FIR_SCHED_OVRRUN_EN
    localparam bit C_OVR_EN = 1'b1;
`else
    localparam bit C_OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic        upd;
    logic        hcsn;
    logic        hwrn;
    logic [5:0]  haddr;
    logic [15:0] hdata;
    logic [5:0]  ncoef;
    logic [3:0]  csn;
    logic [3:0]  wrn;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        en_delay;
    logic        clr_acc;
    logic        en_sum;
    logic [3:0]  en_mac;
    logic        busy;
    logic        ovr;

    int n_tests = 0;
    int n_fail  = 0;
    bit ovr_exp = 1'b0;

    fir_tap_scheduler dut (
        .iClk_12M          (clk),
        .iRst              (rst),
        .iEnSample_600k    (strobe),
        .iCoeffiUpdateFlag (upd),
        .iCsnRam           (hcsn),
        .iWrnRam           (hwrn),
        .iAddrRam          (haddr),
        .iWrDtRam          (hdata),
        .iNumOfCoeff       (ncoef),
        .oCsnRam           (csn),
        .oWrnRam           (wrn),
        .oAddrRam          (addr),
        .oWrDtRam          (wdata),
        .oEnDelay          (en_delay),
        .oClrAcc           (clr_acc),
        .oEnSum            (en_sum),
        .oEnMac            (en_mac),
        .oBusy             (busy),
        .oOvrRun           (ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bank b is selected at tap slot k when global tap 10*b+k is below min(N,40).
    function automatic logic [3:0] ref_csn(input int k, input int n);
        logic [3:0] r;
        int         neff;
        neff = (n > 40) ? 40 : n;
        for (int b = 0; b < 4; b++) begin
            r[b] = !((b * 10 + k) < neff);
        end
        return r;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_val({tag, " csn"},   32'(csn), 32'hF);
        check_val({tag, " wrn"},   32'(wrn), 32'hF);
        check_val({tag, " addr"},  32'(addr), 32'h0);
        check_val({tag, " wdata"}, 32'(wdata), 32'h0);
        check_val({tag, " ctl"},   32'({en_mac, en_delay, clr_acc, en_sum, busy, ovr}), 32'h0);
    endtask

    // Strobe at relative cycle 0, then check every output over cycles +1..+14.
    task automatic run_sample(input int n, input bit overrun);
        string      t;
        logic [3:0] e_csn;
        logic [3:0] e_mac;
        ncoef  = 6'(n);
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        for (int rel = 1; rel <= 14; rel++) begin
            t     = $sformatf("n%0d r%0d", n, rel);
            e_csn = (rel >= 2 && rel <= 11) ? ref_csn(rel - 2, n) : 4'hF;
            e_mac = (rel >= 3 && rel <= 12) ? ~ref_csn(rel - 3, n) : 4'h0;
            if (overrun && rel == 6) ovr_exp = C_OVR_EN;
            check_val({t, " csn"},   32'(csn), 32'(e_csn));
            check_val({t, " wrn"},   32'(wrn), 32'hF);
            check_val({t, " enmac"}, 32'(en_mac), 32'(e_mac));
            if (rel >= 2 && rel <= 11) check_val({t, " addr"}, 32'(addr), 32'(rel - 2));
            check_val({t, " delay"}, 32'(en_delay), 32'(rel == 1));
            check_val({t, " clr"},   32'(clr_acc), 32'(rel == 1));
            check_val({t, " sum"},   32'(en_sum), 32'(rel == 13));
            check_val({t, " busy"},  32'(busy), 32'(rel >= 1 && rel <= 13));
            check_val({t, " ovr"},   32'(ovr), 32'(ovr_exp));
            strobe = (overrun && rel == 5) ? 1'b1 : 1'b0;
            if (rel < 14) step();
        end
    endtask

    // Host write during update mode; result visible one cycle later for one cycle.
    task automatic do_write(input int a, input logic [15:0] d);
        string      t;
        logic [3:0] e_sel;
        t     = $sformatf("wr a%0d", a);
        hcsn  = 1'b0;
        hwrn  = 1'b0;
        haddr = 6'(a);
        hdata = d;
        step();
        hcsn  = 1'b1;
        hwrn  = 1'b1;
        e_sel = (a < 40) ? ~(4'b0001 << (a / 10)) : 4'hF;
        check_val({t, " csn"}, 32'(csn), 32'(e_sel));
        check_val({t, " wrn"}, 32'(wrn), 32'(e_sel));
        if (a < 40) begin
            check_val({t, " addr"},  32'(addr), 32'(a % 10));
            check_val({t, " wdata"}, 32'(wdata), 32'(d));
        end
        check_val({t, " delay"}, 32'(en_delay), 32'h0);
        check_val({t, " ovr"},   32'(ovr), 32'(ovr_exp));
        step();
        check_val({t, " csn+1"}, 32'(csn), 32'hF);
        check_val({t, " wrn+1"}, 32'(wrn), 32'hF);
    endtask

    initial begin
        rst    = 1'b1;
        strobe = 1'b0;
        upd    = 1'b0;
        hcsn   = 1'b1;
        hwrn   = 1'b1;
        haddr  = 6'd0;
        hdata  = 16'd0;
        ncoef  = 6'd0;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        run_sample(40, 1'b0);
        run_sample(33, 1'b0);
        run_sample(0, 1'b0);
        run_sample(63, 1'b0);
        repeat (8) begin
            repeat ($urandom_range(0, 3)) step();
            run_sample(int'($urandom_range(0, 63)), 1'b0);
        end

        // Coefficient update mode.
        upd = 1'b1;
        step();
        do_write(27, 16'h1234);
        do_write(45, 16'hBEEF);
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        check_val("upd strobe delay", 32'(en_delay), 32'h0);
        check_val("upd strobe busy",  32'(busy), 32'h0);
        check_val("upd strobe ovr",   32'(ovr), 32'(ovr_exp));
        hcsn  = 1'b0;
        hwrn  = 1'b1;
        haddr = 6'd5;
        step();
        hcsn = 1'b1;
        check_val("upd read csn", 32'(csn), 32'hF);
        do_write(0, 16'h0001);
        do_write(39, 16'hFFFF);
        repeat (6) do_write(int'($urandom_range(0, 63)), 16'($urandom));
        upd = 1'b0;
        step();
        step();
        check_val("upd exit busy", 32'(busy), 32'h0);
        run_sample(40, 1'b0);

        // Second strobe five cycles after the first.
        run_sample(40, 1'b1);
        run_sample(12, 1'b0);

        // Reset in the middle of a run (MAC k=4 at relative cycle 6).
        ncoef  = 6'd40;
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        repeat (5) step();
        check_val("mid k4 addr", 32'(addr), 32'h4);
        rst = 1'b1;
        #1;
        ovr_exp = 1'b0;
        check_reset_vals("midrst");
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_val($sformatf("post rst %0d sum", i), 32'({en_sum, busy}), 32'h0);
            step();
        end
        run_sample(40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
